// File: rtl/addsub_serial_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The master drives the request; the slave (the datapath) returns status and result.
interface addsub_serial_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract: DIGIT bits per cycle, LSB digit first.
// Carry (add) or borrow (subtract) ripples between cycles; flags update only on completion.
module addsub_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  addsub_serial_if.slave bus
);
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = DIGIT + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             mode_q, mode_d, carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dig_sum;

  // Next-state, digit datapath and completion flags
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    a_dig    = '0;
    b_dig    = '0;

    for (int i = 0; i < int'(N); i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
      end
    end

    // The (DIGIT+1)-bit wrap puts carry-out / borrow-out in the top bit
    if (mode_q) dig_sum = {1'b0, a_dig} - {1'b0, b_dig} - DW'(carry_q);
    else        dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + DW'(carry_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int i = 0; i < int'(N); i++) begin
          if (cnt_q == CW'(i)) result_d[i*DIGIT +: DIGIT] = dig_sum[DIGIT-1:0];
        end
        carry_d = dig_sum[DIGIT];
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          cout_d  = dig_sum[DIGIT];
          ovf_d   = mode_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]))
                           : ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]));
          zero_d  = (result_d == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial in three geometries: (16,4), (8,1), (12,12).
module tb_addsub_serial;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(16)) bus16 ();
  addsub_serial_if #(.WIDTH(8))  bus8  ();
  addsub_serial_if #(.WIDTH(12)) bus12 ();

  addsub_serial #(.WIDTH(16), .DIGIT(4))  dut16 (.clk(clk), .rst(rst), .bus(bus16));
  addsub_serial #(.WIDTH(8),  .DIGIT(1))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  addsub_serial #(.WIDTH(12), .DIGIT(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

  typedef struct {
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] r16;
  logic [7:0]  r8;
  logic [11:0] r12;
  logic [2:0]  f16, f8, f12;
  int lat16, lat8, lat12, bz16, bz8, bz12, dn16, dn8, dn12;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Independent reference: a +/- b modulo 2^w with borrow/carry and signed overflow
  function automatic logic [31:0] model(input int w, input logic m, input logic [15:0] a,
                                        input logic [15:0] b);
    int unsigned mask, av, bv, full, r;
    logic c, o, z, sa, sb, sr;
    mask = (32'd1 << w) - 32'd1;
    av   = 32'(a) & mask;
    bv   = 32'(b) & mask;
    if (!m) begin
      full = av + bv;
      c    = ((full >> w) & 32'd1) != 0;
    end else begin
      full = av - bv;
      c    = av < bv;
    end
    r  = full & mask;
    sa = ((av >> (w - 1)) & 32'd1) != 0;
    sb = ((bv >> (w - 1)) & 32'd1) != 0;
    sr = ((r  >> (w - 1)) & 32'd1) != 0;
    z  = (r == 0);
    o  = m ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {13'd0, c, o, z, r[15:0]};
  endfunction

  // Launch the same operation on all three instances and capture done timing/results
  task automatic do_op(input logic m, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus16.start = 1'b1; bus16.mode = m; bus16.a = a;
    bus8.start  = 1'b1; bus8.mode  = m; bus8.a  = a[7:0];  bus8.b  = b[7:0];
    bus12.start = 1'b1; bus12.mode = m; bus12.a = a[11:0]; bus12.b = b[11:0];
    bus16.b = b;
    @(posedge clk); #1;
    bus16.start = 1'b0; bus8.start = 1'b0; bus12.start = 1'b0;
    lat16 = -1; lat8 = -1; lat12 = -1;
    dn16 = 0; dn8 = 0; dn12 = 0;
    bz16 = int'(bus16.busy); bz8 = int'(bus8.busy); bz12 = int'(bus12.busy);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      bz16 += int'(bus16.busy); bz8 += int'(bus8.busy); bz12 += int'(bus12.busy);
      if (bus16.done) begin
        dn16++;
        if (lat16 < 0) begin lat16 = cyc; r16 = bus16.result; f16 = {bus16.cout, bus16.ovf, bus16.zero}; end
      end
      if (bus8.done) begin
        dn8++;
        if (lat8 < 0) begin lat8 = cyc; r8 = bus8.result; f8 = {bus8.cout, bus8.ovf, bus8.zero}; end
      end
      if (bus12.done) begin
        dn12++;
        if (lat12 < 0) begin lat12 = cyc; r12 = bus12.result; f12 = {bus12.cout, bus12.ovf, bus12.zero}; end
      end
    end
  endtask

  task automatic check_op(input logic m, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] e16, input logic [2:0] ef16);
    logic [31:0] e8, e12;
    e8  = model(8, m, a, b);
    e12 = model(12, m, a, b);
    chk("res16",  32'(r16), 32'(e16));
    chk("flag16", 32'(f16), 32'(ef16));
    chk("lat16",  32'(lat16), 32'd4);
    chk("busy16", 32'(bz16), 32'd4);
    chk("pulse16", 32'(dn16), 32'd1);
    chk("res8",   32'(r8), 32'(e8[15:0]));
    chk("flag8",  32'(f8), 32'(e8[18:16]));
    chk("lat8",   32'(lat8), 32'd8);
    chk("busy8",  32'(bz8), 32'd8);
    chk("pulse8", 32'(dn8), 32'd1);
    chk("res12",  32'(r12), 32'(e12[15:0]));
    chk("flag12", 32'(f12), 32'(e12[18:16]));
    chk("lat12",  32'(lat12), 32'd1);
    chk("busy12", 32'(bz12), 32'd1);
    chk("pulse12", 32'(dn12), 32'd1);
  endtask

  initial begin
    vec_t vecs[10];
    logic [31:0] em;
    logic [15:0] ra, rb;
    logic        rm;
    int          lat, dn;

    vecs[0] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'h0009, 16'h0009, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 16'hABCD, 16'h1234, 16'h9999, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    bus16.start = 1'b0; bus16.mode = 1'b0; bus16.a = '0; bus16.b = '0;
    bus8.start  = 1'b0; bus8.mode  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    bus12.start = 1'b0; bus12.mode = 1'b0; bus12.a = '0; bus12.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset16", 32'({bus16.busy, bus16.done, bus16.cout, bus16.ovf, bus16.zero, bus16.result}), 32'd0);
    chk("reset8",  32'({bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.zero, bus8.result}), 32'd0);
    chk("reset12", 32'({bus12.busy, bus12.done, bus12.cout, bus12.ovf, bus12.zero, bus12.result}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].mode, vecs[i].a, vecs[i].b);
      check_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].res,
               {vecs[i].cout, vecs[i].ovf, vecs[i].zero});
    end

    // Start pulsed on the 2nd RUN cycle with different operands must be ignored
    @(negedge clk);
    bus16.start = 1'b1; bus16.mode = 1'b1; bus16.a = 16'h0005; bus16.b = 16'h0007;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    @(posedge clk); #1;
    bus16.start = 1'b1; bus16.mode = 1'b0; bus16.a = 16'h1000; bus16.b = 16'h0001;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    chk("ign_busy", 32'(bus16.busy), 32'd1);
    lat = -1;
    for (int c = 3; c <= 12 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (bus16.done) lat = c;
    end
    chk("ign_lat", 32'(lat), 32'd4);
    chk("ign_res", 32'(bus16.result), 32'hFFFE);
    chk("ign_flags", 32'({bus16.cout, bus16.ovf, bus16.zero}), 32'b100);
    @(posedge clk); #1;
    chk("ign_pulse_end", 32'({bus16.busy, bus16.done}), 32'b00);

    // Start held through DONE chains a second operation with no idle cycle
    @(negedge clk);
    bus16.start = 1'b1; bus16.mode = 1'b0; bus16.a = 16'h0001; bus16.b = 16'h0002;
    @(posedge clk); #1;
    bus16.mode = 1'b1; bus16.a = 16'h0010; bus16.b = 16'h0003;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    chk("b2b_done1", 32'({bus16.done, bus16.result}), {15'd0, 1'b1, 16'h0003});
    @(posedge clk); #1;
    bus16.start = 1'b0;
    chk("b2b_nogap", 32'({bus16.busy, bus16.done}), 32'b10);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    chk("b2b_done2", 32'({bus16.done, bus16.cout, bus16.ovf, bus16.zero, bus16.result}),
        {12'd0, 4'b1000, 16'h000D});
    @(posedge clk); #1;
    chk("b2b_end", 32'(bus16.done), 32'd0);

    // Reset on the 3rd RUN cycle aborts with no done pulse
    @(negedge clk);
    bus16.start = 1'b1; bus16.mode = 1'b0; bus16.a = 16'h1111; bus16.b = 16'h2222;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_outs", 32'({bus16.busy, bus16.done, bus16.cout, bus16.ovf, bus16.zero, bus16.result}), 32'd0);
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      dn += int'(bus16.done);
    end
    chk("abort_nodone", 32'(dn), 32'd0);
    do_op(1'b0, 16'h1111, 16'h2222);
    check_op(1'b0, 16'h1111, 16'h2222, 16'h3333, 3'b000);

    // Random sweep against the reference model
    for (int k = 0; k < 16; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 1'($urandom_range(0, 1));
      do_op(rm, ra, rb);
      em = model(16, rm, ra, rb);
      check_op(rm, ra, rb, em[15:0], em[18:16]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
